// File: rtl/gpio_apb_regs.sv
// APB3 completer register file for the 32-pin GPIO bank: pin direction and
// output configuration, synchronized input readback, and sticky per-pin
// interrupt status with enable masking and a registered level interrupt.
//
// Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0) and then
// enters access (PSEL=1, PENABLE=1). PREADY rises after WAIT_STATES access
// cycles, and the transfer completes on the rising PCLK edge where
// PSEL & PENABLE & PREADY. PSLVERR and PRDATA are only meaningful while
// PREADY=1, and both read 0 at all other times. When PSEL drops before
// completion, the transfer is abandoned and nothing is committed.
module gpio_apb_regs #(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [31:0]       sync_gpio_in,
    input  logic [31:0]       irq_event,
    output logic [31:0]       gpio_dir,
    output logic [31:0]       gpio_out_reg,
    output logic              irq
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    // Register indices (PADDR[5:2])
    localparam logic [3:0] IDX_DIR        = 4'd0;
    localparam logic [3:0] IDX_OUT        = 4'd1;
    localparam logic [3:0] IDX_OUT_SET    = 4'd2;
    localparam logic [3:0] IDX_OUT_CLR    = 4'd3;
    localparam logic [3:0] IDX_OUT_TGL    = 4'd4;
    localparam logic [3:0] IDX_IN         = 4'd5;
    localparam logic [3:0] IDX_IRQ_EN     = 4'd6;
    localparam logic [3:0] IDX_IRQ_STATUS = 4'd7;
    localparam logic [3:0] IDX_IRQ_MASKED = 4'd8;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] dir_q, dir_d;
    logic [31:0] out_q, out_d;
    logic [31:0] en_q, en_d;
    logic [31:0] status_q, status_d;
    logic        irq_q, irq_d;

    logic        setup_phase;
    logic        access_phase;
    logic [3:0]  idx;
    logic        addr_hi_nz;
    logic        unmapped;
    logic        dec_err;
    logic        commit;
    logic [31:0] w1c_mask;
    logic [31:0] rdata_mux;
    logic        unused_paddr_lo;

    // Byte-lane bits are not decoded.
    assign unused_paddr_lo = ^PADDR[1:0];

    assign setup_phase  = PSEL & ~PENABLE;
    assign access_phase = PSEL & PENABLE;
    assign idx          = PADDR[5:2];

    // Address bits above the 64-byte window select nothing, so an access
    // such as 0x40 is reported as unmapped instead of aliasing DIR.
    generate
        if (ADDR_W > 6) begin : g_hi
            assign addr_hi_nz = |PADDR[ADDR_W-1:6];
        end else begin : g_no_hi
            assign addr_hi_nz = 1'b0;
        end
    endgenerate

    assign unmapped = addr_hi_nz | (idx > IDX_IRQ_MASKED);
    assign dec_err  = unmapped |
                      (PWRITE & ((idx == IDX_IN) | (idx == IDX_IRQ_MASKED)));

    assign PREADY  = access_phase & (cnt_q == WS);
    assign PSLVERR = PREADY & dec_err;
    assign commit  = PREADY & PWRITE & ~dec_err;

    // Handshake FSM: track setup/access and count wait states
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (setup_phase) begin
                    state_d = ACCESS;
                    cnt_d   = 4'd0;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    // Transfer abandoned before completion.
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (setup_phase) begin
                    cnt_d = 4'd0;
                end else if (PREADY) begin
                    state_d = IDLE;
                end else if (cnt_q < WS) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Read mux over the current register state; gated to 0 unless completing
    always_comb begin
        rdata_mux = 32'd0;
        case (idx)
            IDX_DIR:        rdata_mux = dir_q;
            IDX_OUT:        rdata_mux = out_q;
            IDX_IN:         rdata_mux = sync_gpio_in;
            IDX_IRQ_EN:     rdata_mux = en_q;
            IDX_IRQ_STATUS: rdata_mux = status_q;
            IDX_IRQ_MASKED: rdata_mux = status_q & en_q;
            default:        rdata_mux = 32'd0;
        endcase
        PRDATA = (PREADY && !unmapped) ? rdata_mux : 32'd0;
    end

    // Register updates on the completing edge; events always set status bits
    always_comb begin
        dir_d    = dir_q;
        out_d    = out_q;
        en_d     = en_q;
        w1c_mask = 32'd0;
        if (commit) begin
            case (idx)
                IDX_DIR:        dir_d    = PWDATA;
                IDX_OUT:        out_d    = PWDATA;
                IDX_OUT_SET:    out_d    = out_q | PWDATA;
                IDX_OUT_CLR:    out_d    = out_q & ~PWDATA;
                IDX_OUT_TGL:    out_d    = out_q ^ PWDATA;
                IDX_IRQ_EN:     en_d     = PWDATA;
                IDX_IRQ_STATUS: w1c_mask = PWDATA;
                default:        w1c_mask = 32'd0;
            endcase
        end
        // A new event wins over a simultaneous clear so nothing is lost.
        status_d = (status_q & ~w1c_mask) | irq_event;
        irq_d    = |(status_q & en_q);
    end

    // State and register flops
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            dir_q    <= 32'd0;
            out_q    <= 32'd0;
            en_q     <= 32'd0;
            status_q <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            out_q    <= out_d;
            en_q     <= en_d;
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign gpio_dir     = dir_q;
    assign gpio_out_reg = out_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_gpio_apb_regs.sv
// Bench for gpio_apb_regs: one instance with no wait states, one with three.
// The two instances share the APB bus lines and have separate PSEL inputs.
module tb_gpio_apb_regs;

    logic        PCLK;
    logic        PRESETn;
    logic        psel0, psel1;
    logic        PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] sync_gpio_in, irq_event;

    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;
    logic [31:0] gpio_dir0, gpio_dir1, gpio_out_reg0, gpio_out_reg1;
    logic        irq0, irq1;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    gpio_apb_regs #(.WAIT_STATES(0), .ADDR_W(8)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata0),
        .PREADY(pready0), .PSLVERR(pslverr0), .sync_gpio_in(sync_gpio_in),
        .irq_event(irq_event), .gpio_dir(gpio_dir0), .gpio_out_reg(gpio_out_reg0),
        .irq(irq0)
    );

    gpio_apb_regs #(.WAIT_STATES(3), .ADDR_W(8)) dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel1), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata1),
        .PREADY(pready1), .PSLVERR(pslverr1), .sync_gpio_in(sync_gpio_in),
        .irq_event(irq_event), .gpio_dir(gpio_dir1), .gpio_out_reg(gpio_out_reg1),
        .irq(irq1)
    );

    // Clock and reset
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // One APB transfer on the selected instance; returns data, error and the
    // number of access cycles with PREADY low.
    task automatic apb_xfer(input int sel, input logic wr, input logic [7:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic err, output int waits);
        logic done;
        logic rdy;
        rdata = 32'd0;
        err   = 1'b0;
        waits = 0;
        done  = 1'b0;
        @(negedge PCLK);
        psel0   = (sel == 0);
        psel1   = (sel == 1);
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        @(negedge PCLK);
        PENABLE = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            rdy = (sel == 0) ? pready0 : pready1;
            if (rdy) begin
                rdata = (sel == 0) ? prdata0 : prdata1;
                err   = (sel == 0) ? pslverr0 : pslverr1;
                done  = 1'b1;
                break;
            end
            waits++;
            @(negedge PCLK);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout addr=%h got no PREADY need PREADY within 40 cycles", addr);
        end
    endtask

    task automatic bus_idle();
        @(negedge PCLK);
        psel0   = 1'b0;
        psel1   = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge PCLK);
        #1;
        checks++;
        if ({gpio_dir0, gpio_out_reg0, irq0} !== 65'd0) begin
            errors++;
            $display("FAIL reset_outs0 got=%h need=0", {gpio_dir0, gpio_out_reg0, irq0});
        end
        checks++;
        if ({pready0, pslverr0, prdata0} !== 34'd0) begin
            errors++;
            $display("FAIL reset_apb0 got=%h need=0", {pready0, pslverr0, prdata0});
        end
        checks++;
        if ({gpio_dir1, gpio_out_reg1, irq1, pready1, pslverr1, prdata1} !== 99'd0) begin
            errors++;
            $display("FAIL reset_all1 got nonzero outputs need all 0");
        end
    endtask

    task automatic test_dir();
        logic [31:0] rd;
        logic        err;
        int          w;
        logic [32:0] exp;
        apb_xfer(0, 1'b1, 8'h00, 32'hA5A5_0F0F, rd, err, w);
        bus_idle();
        #1;
        checks++;
        if (gpio_dir0 !== 32'hA5A5_0F0F) begin
            errors++;
            $display("FAIL dir_out got=%h need=%h", gpio_dir0, 32'hA5A5_0F0F);
        end
        exp_q.push_back({1'b0, 32'hA5A5_0F0F});
        apb_xfer(0, 1'b0, 8'h00, 32'd0, rd, err, w);
        exp = exp_q.pop_front();
        checks++;
        if ({err, rd} !== exp) begin
            errors++;
            $display("FAIL dir_read got=%h need=%h", {err, rd}, exp);
        end
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL dir_read_waits got=%0d need=0", w);
        end
        bus_idle();
    endtask

    task automatic test_out_ops();
        logic [31:0] rd;
        logic        err;
        int          w;
        logic [32:0] exp;
        logic [7:0]  wo_addr[3];
        wo_addr[0] = 8'h08;
        wo_addr[1] = 8'h0C;
        wo_addr[2] = 8'h10;
        apb_xfer(0, 1'b1, 8'h04, 32'h0000_00FF, rd, err, w);
        apb_xfer(0, 1'b1, 8'h08, 32'h0000_0F00, rd, err, w);
        apb_xfer(0, 1'b1, 8'h0C, 32'h0000_000F, rd, err, w);
        apb_xfer(0, 1'b1, 8'h10, 32'h0000_0101, rd, err, w);
        bus_idle();
        #1;
        checks++;
        if (gpio_out_reg0 !== 32'h0000_0EF1) begin
            errors++;
            $display("FAIL out_ops got=%h need=%h", gpio_out_reg0, 32'h0000_0EF1);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, 32'd0});
            apb_xfer(0, 1'b0, wo_addr[i], 32'd0, rd, err, w);
            exp = exp_q.pop_front();
            checks++;
            if ({err, rd} !== exp) begin
                errors++;
                $display("FAIL wo_read_%h got=%h need=%h", wo_addr[i], {err, rd}, exp);
            end
        end
        exp_q.push_back({1'b0, 32'h0000_0EF1});
        apb_xfer(0, 1'b0, 8'h04, 32'd0, rd, err, w);
        exp = exp_q.pop_front();
        checks++;
        if ({err, rd} !== exp) begin
            errors++;
            $display("FAIL out_read got=%h need=%h", {err, rd}, exp);
        end
        bus_idle();
    endtask

    task automatic test_in_and_errors();
        logic [31:0] rd;
        logic        err;
        int          w;
        logic [32:0] exp;
        sync_gpio_in = 32'h1234_5678;
        exp_q.push_back({1'b0, 32'h1234_5678});
        apb_xfer(0, 1'b0, 8'h14, 32'd0, rd, err, w);
        exp = exp_q.pop_front();
        checks++;
        if ({err, rd} !== exp) begin
            errors++;
            $display("FAIL in_read got=%h need=%h", {err, rd}, exp);
        end
        apb_xfer(0, 1'b1, 8'h14, 32'hFFFF_FFFF, rd, err, w);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL in_write_err got=%b need=1", err);
        end
        apb_xfer(0, 1'b1, 8'h20, 32'hFFFF_FFFF, rd, err, w);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL masked_write_err got=%b need=1", err);
        end
        exp_q.push_back({1'b1, 32'd0});
        apb_xfer(0, 1'b0, 8'h40, 32'd0, rd, err, w);
        exp = exp_q.pop_front();
        checks++;
        if ({err, rd} !== exp) begin
            errors++;
            $display("FAIL unmapped_40 got=%h need=%h", {err, rd}, exp);
        end
        exp_q.push_back({1'b1, 32'd0});
        apb_xfer(0, 1'b0, 8'h24, 32'd0, rd, err, w);
        exp = exp_q.pop_front();
        checks++;
        if ({err, rd} !== exp) begin
            errors++;
            $display("FAIL unmapped_24 got=%h need=%h", {err, rd}, exp);
        end
        apb_xfer(0, 1'b1, 8'h40, 32'h1111_1111, rd, err, w);
        apb_xfer(0, 1'b1, 8'h24, 32'h2222_2222, rd, err, w);
        bus_idle();
        #1;
        checks++;
        if ({gpio_dir0, gpio_out_reg0} !== {32'hA5A5_0F0F, 32'h0000_0EF1}) begin
            errors++;
            $display("FAIL err_no_change got=%h need=%h", {gpio_dir0, gpio_out_reg0},
                     {32'hA5A5_0F0F, 32'h0000_0EF1});
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        logic        err;
        int          w;
        logic [32:0] exp;
        apb_xfer(0, 1'b1, 8'h18, 32'h0000_0001, rd, err, w);
        bus_idle();
        irq_event = 32'h0000_0008;
        @(negedge PCLK);
        irq_event = 32'd0;
        @(negedge PCLK);
        #1;
        checks++;
        if (irq0 !== 1'b0) begin
            errors++;
            $display("FAIL irq_masked_bit3 got=%b need=0", irq0);
        end
        exp_q.push_back({1'b0, 32'h0000_0008});
        apb_xfer(0, 1'b0, 8'h1C, 32'd0, rd, err, w);
        exp = exp_q.pop_front();
        checks++;
        if ({err, rd} !== exp) begin
            errors++;
            $display("FAIL status_bit3 got=%h need=%h", {err, rd}, exp);
        end
        bus_idle();
        irq_event = 32'h0000_0001;
        @(negedge PCLK);
        irq_event = 32'd0;
        #1;
        checks++;
        if (irq0 !== 1'b0) begin
            errors++;
            $display("FAIL irq_not_early got=%b need=0", irq0);
        end
        @(negedge PCLK);
        #1;
        checks++;
        if (irq0 !== 1'b1) begin
            errors++;
            $display("FAIL irq_assert got=%b need=1", irq0);
        end
        // W1C of bit 0 in the same edge as a new bit-0 event
        irq_event = 32'h0000_0001;
        apb_xfer(0, 1'b1, 8'h1C, 32'h0000_0001, rd, err, w);
        bus_idle();
        irq_event = 32'd0;
        exp_q.push_back({1'b0, 32'h0000_0009});
        apb_xfer(0, 1'b0, 8'h1C, 32'd0, rd, err, w);
        exp = exp_q.pop_front();
        checks++;
        if ({err, rd} !== exp) begin
            errors++;
            $display("FAIL set_wins_w1c got=%h need=%h", {err, rd}, exp);
        end
        exp_q.push_back({1'b0, 32'h0000_0001});
        apb_xfer(0, 1'b0, 8'h20, 32'd0, rd, err, w);
        exp = exp_q.pop_front();
        checks++;
        if ({err, rd} !== exp) begin
            errors++;
            $display("FAIL masked_read got=%h need=%h", {err, rd}, exp);
        end
        apb_xfer(0, 1'b1, 8'h1C, 32'h0000_0009, rd, err, w);
        exp_q.push_back({1'b0, 32'd0});
        apb_xfer(0, 1'b0, 8'h1C, 32'd0, rd, err, w);
        exp = exp_q.pop_front();
        checks++;
        if ({err, rd} !== exp) begin
            errors++;
            $display("FAIL w1c_clear got=%h need=%h", {err, rd}, exp);
        end
        bus_idle();
        @(negedge PCLK);
        #1;
        checks++;
        if (irq0 !== 1'b0) begin
            errors++;
            $display("FAIL irq_deassert got=%b need=0", irq0);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic        err;
        int          w;
        logic [32:0] exp;
        apb_xfer(1, 1'b1, 8'h04, 32'h0000_0055, rd, err, w);
        checks++;
        if (w !== 3 || err !== 1'b0) begin
            errors++;
            $display("FAIL ws_write got waits=%0d err=%b need waits=3 err=0", w, err);
        end
        bus_idle();
        #1;
        checks++;
        if ({pready1, gpio_out_reg1} !== {1'b0, 32'h0000_0055}) begin
            errors++;
            $display("FAIL ws_commit got=%h need=%h", {pready1, gpio_out_reg1},
                     {1'b0, 32'h0000_0055});
        end
        // Abort after two access cycles
        @(negedge PCLK);
        psel1   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 8'h04;
        PWDATA  = 32'h0000_00AA;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        checks++;
        if (pready1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready1 got=%b need=0", pready1);
        end
        @(negedge PCLK);
        #1;
        checks++;
        if (pready1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready2 got=%b need=0", pready1);
        end
        bus_idle();
        @(negedge PCLK);
        #1;
        checks++;
        if (gpio_out_reg1 !== 32'h0000_0055) begin
            errors++;
            $display("FAIL abort_no_commit got=%h need=%h", gpio_out_reg1, 32'h0000_0055);
        end
        exp_q.push_back({1'b0, 32'h0000_0055});
        apb_xfer(1, 1'b0, 8'h04, 32'd0, rd, err, w);
        exp = exp_q.pop_front();
        checks++;
        if ({err, rd} !== exp || w !== 3) begin
            errors++;
            $display("FAIL ws_read got=%h waits=%0d need=%h waits=3", {err, rd}, w, exp);
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        err;
        int          w;
        logic [32:0] exp;
        logic [31:0] val;
        for (int i = 0; i < 4; i++) begin
            val = $urandom_range(32'hFFFF_FFFF, 0);
            apb_xfer(1, 1'b1, 8'h00, val, rd, err, w);
            exp_q.push_back({1'b0, val});
            apb_xfer(1, 1'b0, 8'h00, 32'd0, rd, err, w);
            exp = exp_q.pop_front();
            checks++;
            if ({err, rd} !== exp) begin
                errors++;
                $display("FAIL b2b_%0d got=%h need=%h", i, {err, rd}, exp);
            end
        end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        err;
        int          w;
        logic [32:0] exp;
        @(negedge PCLK);
        psel1   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 8'h04;
        PWDATA  = 32'hFFFF_0000;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        checks++;
        if ({pready1, gpio_out_reg1} !== 33'd0) begin
            errors++;
            $display("FAIL rst_mid got=%h need=0", {pready1, gpio_out_reg1});
        end
        @(negedge PCLK);
        psel1   = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        exp_q.push_back({1'b0, 32'd0});
        apb_xfer(1, 1'b0, 8'h04, 32'd0, rd, err, w);
        exp = exp_q.pop_front();
        checks++;
        if ({err, rd} !== exp || gpio_out_reg1 !== 32'd0) begin
            errors++;
            $display("FAIL rst_no_write got=%h out=%h need=%h out=0", {err, rd},
                     gpio_out_reg1, exp);
        end
        bus_idle();
    endtask

    initial begin
        PRESETn      = 1'b0;
        psel0        = 1'b0;
        psel1        = 1'b0;
        PENABLE      = 1'b0;
        PWRITE       = 1'b0;
        PADDR        = 8'd0;
        PWDATA       = 32'd0;
        sync_gpio_in = 32'd0;
        irq_event    = 32'd0;
        test_reset();
        @(negedge PCLK);
        PRESETn = 1'b1;
        test_dir();
        test_out_ops();
        test_in_and_errors();
        test_irq();
        test_wait_states();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got=%0d need=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_apb_regs.md
Name: gpio_apb_regs

Overview:
APB3 responder (completer) register file for the 32-pin GPIO bank. It produces the per-pin direction and output-value configuration consumed by the pin block, and reads back the synchronized pin inputs. It latches per-pin interrupt events from the debounce/edge logic into a sticky status register with enable masking, and drives a single level interrupt. It supports a configurable number of APB wait states.

Parameters:
WAIT_STATES, 0, number of PREADY-low cycles in the access phase before completion (0..15).
ADDR_W, 8, width of PADDR; only PADDR[5:2] is decoded, PADDR[1:0] is ignored.

Ports:
PCLK  in  1  APB clock
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_W  byte address
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  error response, valid only when PREADY=1
sync_gpio_in  in  32  synchronized pin levels
irq_event  in  32  single-cycle per-pin event pulses
gpio_dir  out  32  1 = output
gpio_out_reg  out  32  value driven when output
irq  out  1  level interrupt

Behaviour:
- Reset: PCLK is the clock; PRESETn is the asynchronous active-low reset. It clears gpio_dir, gpio_out_reg, IRQ_EN, IRQ_STATUS, the wait counter and irq to 0. PREADY=0, PSLVERR=0, PRDATA=0.
- Register map (byte offsets):
  - 0x00 DIR: RW.
  - 0x04 OUT: RW.
  - 0x08 OUT_SET: WO; OUT |= PWDATA.
  - 0x0C OUT_CLR: WO; OUT &= ~PWDATA.
  - 0x10 OUT_TGL: WO; OUT ^= PWDATA.
  - 0x14 IN: RO; returns sync_gpio_in.
  - 0x18 IRQ_EN: RW.
  - 0x1C IRQ_STATUS: RW1C.
  - 0x20 IRQ_MASKED: RO; returns STATUS & EN.
- Decode errors:
  - Unmapped offset (0x24 and above): PSLVERR=1, PRDATA=0, no state change.
  - Write to IN or IRQ_MASKED: PSLVERR=1, ignored.
  - Read of a WO register returns 0 with PSLVERR=0.
- Handshake (two-state FSM, IDLE and ACCESS):
  - Setup cycle (PSEL=1, PENABLE=0) clears the wait counter.
  - In ACCESS (PSEL=1, PENABLE=1) the counter increments each cycle while below WAIT_STATES.
  - PREADY = PSEL & PENABLE & (cnt == WAIT_STATES). With WAIT_STATES=0, PREADY=1 in the first access cycle.
  - Outside access, PREADY=0 and PSLVERR=0.
- Commit: a write takes effect only on the completing edge (PSEL & PENABLE & PREADY). New register values are visible on outputs the following cycle.
- Read data: PRDATA is a combinational mux of the current register state, valid when PREADY=1; PRDATA=0 otherwise.
- Abort: PSEL dropping before completion returns the FSM to IDLE, clears the counter and commits nothing.
- Status update, per bit:
  - next = (status & ~w1c_mask) | irq_event.
  - A set wins over a simultaneous W1C clear, so no event is lost.
  - Events are latched regardless of IRQ_EN.
- irq = |(IRQ_STATUS & IRQ_EN), registered; it asserts the cycle after the status or enable flops change.
- Back-to-back transfers (setup immediately after completion) are supported with no idle cycle.
- Reset asserted mid-transfer aborts the transfer immediately; no partial write commits.

Test Plan:
- Reset with WAIT_STATES=0 → all outputs 0. Write DIR=0xA5A5_0F0F → gpio_dir=0xA5A5_0F0F one cycle after completion. Read 0x00 returns same with PREADY high in the first access cycle and PSLVERR=0.
- OUT=0x0000_00FF, then SET 0x0000_0F00, CLR 0x0000_000F, TGL 0x0000_0101 → gpio_out_reg=0x0000_0EF1. Reads of 0x08/0x0C/0x10 return 0.
- Drive sync_gpio_in=0x1234_5678 → read 0x14 returns 0x1234_5678. Write 0x14 → PSLVERR=1 and no change. Read 0x40 → PSLVERR=1, PRDATA=0.
- Set IRQ_EN=0x0000_0001, pulse irq_event bit 3 → STATUS=0x8 and irq stays 0. Pulse bit 0 → irq=1 the next cycle. Write 0x1 to 0x1C in the same cycle as a new bit-0 pulse → STATUS bit 0 remains 1.
- Set WAIT_STATES=3 → PREADY low for exactly 3 access cycles, then high for 1. Drop PSEL after 2 access cycles → no register change.
- Assert PRESETn low during a wait-stated write to OUT → gpio_out_reg=0, PREADY=0, and the write is never applied.
